construtor_caminho: RTL
=======================

// Module: construtor_caminho
// PURPOSE
//  Path-reconstruction sequencer, started by the state-machine controller's construir_caminho pulse once the search ends.
//  Walks the predecessor ("anterior") memory from destino back to fonte, one read per node.
//  Pushes each node onto an internal LIFO, then streams the path fonte->destino on a valid/ready output.
//  Flags a walk that overflows the LIFO (corrupt or looping predecessor chain).
// PARAMETERS
//  ADDR_WIDTH  6   node address width
//  MAX_PATH    64  LIFO depth, max nodes in a path (2**ADDR_WIDTH)
//  CNT_WIDTH   7   node-count width, holds 0..MAX_PATH
// PORTS
//  clk                  in   1           clock, all logic on posedge
//  rst_n                in   1           asynchronous, active-low reset
//  cme_construir_in     in   1           start pulse, sampled only in IDLE
//  fonte_in             in   ADDR_WIDTH  source node, captured on accepted start
//  destino_in           in   ADDR_WIDTH  destination node, captured on accepted start
//  ant_rd_en_out        out  1           predecessor memory read enable
//  ant_rd_addr_out      out  ADDR_WIDTH  predecessor memory read address
//  ant_rd_data_in       in   ADDR_WIDTH  predecessor of addressed node, valid 1 cycle after rd_en
//  cc_valid_out         out  1           path beat valid
//  cc_addr_out          out  ADDR_WIDTH  path node, fonte first
//  cc_last_out          out  1           beat is destino (final node)
//  saida_ready_in       in   1           downstream accepts beat (valid & ready)
//  cc_tamanho_out       out  CNT_WIDTH   node count of current path (held until next start)
//  cc_ocupado_out       out  1           high in any state except IDLE
//  cc_pronto_out        out  1           one-cycle pulse after last beat accepted
//  cc_erro_out          out  1           one-cycle pulse on LIFO overflow
// BEHAVIOUR
//  Reset: FSM=IDLE; LIFO count=0; all outputs 0; captured fonte/destino/atual=0.
//  States: IDLE, EMPILHA, ESPERA, EMITIR, ERRO.
//  IDLE: on cme_construir_in=1: fonte<=fonte_in, atual<=destino_in, count<=0, tamanho<=0 -> EMPILHA.
//  EMPILHA:
//   - count==MAX_PATH -> ERRO, no push.
//   - else push atual, count+1, tamanho+1.
//     - atual==fonte -> EMITIR.
//     - else ant_rd_en_out=1, ant_rd_addr_out=atual -> ESPERA.
//  ESPERA: atual<=ant_rd_data_in -> EMPILHA. ant_rd_en_out=0.
//  ant_rd_en_out is combinational in EMPILHA only, so exactly one read per non-fonte node.
//  EMITIR:
//   - cc_valid_out=1, cc_addr_out=LIFO top, cc_last_out=(count==1).
//   - On valid&ready: pop, count-1; if count was 1 -> IDLE and cc_pronto_out=1 next cycle.
//   - With ready=0, addr/last are held stable; no beat is ever dropped or duplicated.
//  ERRO: cc_erro_out=1 for one cycle, count<=0 -> IDLE. No beats are emitted for the failed walk.
//  Start while ocupado=1 is ignored with no side effects.
//  Latency: path of N nodes -> first valid 2N cycles after the start edge (N=1 -> 2 cycles).
//  Throughput: one beat per cycle while ready=1.
//  cc_valid_out and ant_rd_en_out are never high in the same cycle.
//  Reset asserted mid-operation aborts immediately to reset state; no pronto/erro pulse.
//  Counters never wrap: count is bounded 0..MAX_PATH by the ERRO check.
// TESTING
//  T1 fonte=destino=5, start -> 0 reads; one beat addr=5 last=1 at start+2; tamanho=1; pronto next cycle.
//  T2 anterior[9]=4, anterior[4]=2, fonte=2, destino=9, ready=1 -> reads @9,@4; beats 2,4,9; last on 9; tamanho=3.
//  T3 T2 with ready toggling 1010.. and held low 5 cycles -> beats stay 2,4,9, stable while stalled.
//  T4 anterior[3]=7, anterior[7]=3, fonte=1, destino=3 -> 64 pushes; erro pulse; valid never high; back to IDLE.
//  T5 start pulse mid-walk -> ignored, T2 result unchanged.
//     Reset during EMITIR -> all outputs 0; fresh T1 then passes.

Source files
------------

// File: rtl/construtor_caminho.sv
// Path-reconstruction sequencer.
// Once the search has finished, the controller pulses cme_construir_in. The
// block then walks the predecessor ("anterior") memory from destino back to
// fonte, issuing one read per node. Each visited node is pushed onto an
// internal LIFO. The path is then streamed out fonte-first. A walk that would
// overflow the LIFO indicates a corrupt or looping predecessor chain; it is
// reported with a one-cycle erro pulse and produces no beats.
//
// Output handshake: a beat (cc_addr_out, cc_last_out) transfers on every
// rising clk edge where cc_valid_out & saida_ready_in are both high. Once
// valid is raised it stays high, with addr/last stable, until the beat is
// accepted. Valid never depends on ready.
module construtor_caminho #(
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_PATH   = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cme_construir_in,
    input  logic [ADDR_WIDTH-1:0] fonte_in,
    input  logic [ADDR_WIDTH-1:0] destino_in,
    output logic                  ant_rd_en_out,
    output logic [ADDR_WIDTH-1:0] ant_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0] ant_rd_data_in,
    output logic                  cc_valid_out,
    output logic [ADDR_WIDTH-1:0] cc_addr_out,
    output logic                  cc_last_out,
    input  logic                  saida_ready_in,
    output logic [CNT_WIDTH-1:0]  cc_tamanho_out,
    output logic                  cc_ocupado_out,
    output logic                  cc_pronto_out,
    output logic                  cc_erro_out
);

    localparam int IDX_W = $clog2(MAX_PATH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EMPILHA = 3'd1;
    localparam logic [2:0] ESPERA  = 3'd2;
    localparam logic [2:0] EMITIR  = 3'd3;
    localparam logic [2:0] ERRO    = 3'd4;

    logic [2:0]            estado;
    logic [ADDR_WIDTH-1:0] fonte_q;
    logic [ADDR_WIDTH-1:0] atual_q;
    logic [CNT_WIDTH-1:0]  count_q;
    logic [CNT_WIDTH-1:0]  tamanho_q;
    logic                  pronto_q;
    logic [ADDR_WIDTH-1:0] pilha [MAX_PATH];

    logic                  cheio;
    logic                  push;
    logic                  pop;
    logic                  no_fonte;
    logic [CNT_WIDTH-1:0]  topo_idx;
    logic [ADDR_WIDTH-1:0] topo;

    // LIFO bookkeeping and handshake qualifiers
    always_comb begin
        cheio    = (count_q == CNT_WIDTH'(MAX_PATH));
        push     = (estado == EMPILHA) && !cheio;
        pop      = (estado == EMITIR) && saida_ready_in;
        no_fonte = (atual_q == fonte_q);
        topo_idx = count_q - CNT_WIDTH'(1);
        topo     = pilha[topo_idx[IDX_W-1:0]];
    end

    // Output decode: reads only from EMPILHA, beats only from EMITIR, so the two never overlap
    always_comb begin
        ant_rd_en_out   = push && !no_fonte;
        ant_rd_addr_out = ant_rd_en_out ? atual_q : '0;
        cc_valid_out    = (estado == EMITIR);
        cc_addr_out     = cc_valid_out ? topo : '0;
        cc_last_out     = cc_valid_out && (count_q == CNT_WIDTH'(1));
        cc_tamanho_out  = tamanho_q;
        cc_ocupado_out  = (estado != IDLE);
        cc_pronto_out   = pronto_q;
        cc_erro_out     = (estado == ERRO);
    end

    // LIFO storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pilha[count_q[IDX_W-1:0]] <= atual_q;
        end
    end

    // Control FSM: capture, walk/push, wait for read data, emit, overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= IDLE;
            fonte_q   <= '0;
            atual_q   <= '0;
            count_q   <= '0;
            tamanho_q <= '0;
            pronto_q  <= 1'b0;
        end else begin
            pronto_q <= pop && (count_q == CNT_WIDTH'(1));
            case (estado)
                IDLE: begin
                    if (cme_construir_in) begin
                        fonte_q   <= fonte_in;
                        atual_q   <= destino_in;
                        count_q   <= '0;
                        tamanho_q <= '0;
                        estado    <= EMPILHA;
                    end
                end
                EMPILHA: begin
                    if (cheio) begin
                        estado <= ERRO;
                    end else begin
                        count_q   <= count_q + CNT_WIDTH'(1);
                        tamanho_q <= tamanho_q + CNT_WIDTH'(1);
                        estado    <= no_fonte ? EMITIR : ESPERA;
                    end
                end
                ESPERA: begin
                    atual_q <= ant_rd_data_in;
                    estado  <= EMPILHA;
                end
                EMITIR: begin
                    if (saida_ready_in) begin
                        count_q <= count_q - CNT_WIDTH'(1);
                        if (count_q == CNT_WIDTH'(1)) begin
                            estado <= IDLE;
                        end
                    end
                end
                ERRO: begin
                    count_q <= '0;
                    estado  <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule
